// File: rtl/csr_pkg.sv
// CSR address map, per-CSR write masks, reset values and field positions shared by
// the CSR register file, its bus interface and the constant timer.
package csr_pkg;

    typedef logic [13:0] csr_addr_t;

    localparam csr_addr_t CSR_CRMD   = 14'h000;
    localparam csr_addr_t CSR_PRMD   = 14'h001;
    localparam csr_addr_t CSR_ECFG   = 14'h004;
    localparam csr_addr_t CSR_ESTAT  = 14'h005;
    localparam csr_addr_t CSR_ERA    = 14'h006;
    localparam csr_addr_t CSR_EENTRY = 14'h00c;
    localparam csr_addr_t CSR_SAVE0  = 14'h030;
    localparam csr_addr_t CSR_SAVE1  = 14'h031;
    localparam csr_addr_t CSR_SAVE2  = 14'h032;
    localparam csr_addr_t CSR_SAVE3  = 14'h033;
    localparam csr_addr_t CSR_TID    = 14'h040;
    localparam csr_addr_t CSR_TCFG   = 14'h041;
    localparam csr_addr_t CSR_TVAL   = 14'h042;
    localparam csr_addr_t CSR_TICLR  = 14'h044;

    localparam logic [31:0] MASK_CRMD   = 32'h0000_01ff;
    localparam logic [31:0] MASK_PRMD   = 32'h0000_0007;
    localparam logic [31:0] MASK_ECFG   = 32'h0000_1bff;
    localparam logic [31:0] MASK_ESTAT  = 32'h0000_0003;
    localparam logic [31:0] MASK_EENTRY = 32'hffff_ffc0;

    localparam logic [31:0] RST_CRMD = 32'h0000_0008;

    localparam int CRMD_IE       = 2;
    localparam int ESTAT_TI      = 11;
    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;

    typedef enum logic [5:0] {
        ECODE_INT  = 6'h00,
        ECODE_PIL  = 6'h01,
        ECODE_PIS  = 6'h02,
        ECODE_PIF  = 6'h03,
        ECODE_PME  = 6'h04,
        ECODE_PPI  = 6'h07,
        ECODE_ADE  = 6'h08,
        ECODE_ALE  = 6'h09,
        ECODE_SYS  = 6'h0b,
        ECODE_BRK  = 6'h0c,
        ECODE_INE  = 6'h0d,
        ECODE_IPE  = 6'h0e,
        ECODE_FPD  = 6'h0f,
        ECODE_TLBR = 6'h3f
    } csr_ecode_e;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Bus bundle between the pipeline (master: execute read port, WB commit port, interrupt lines)
// and the CSR register file (slave).
interface csr_regfile_if;
    import csr_pkg::*;

    csr_addr_t   rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    csr_addr_t   wr_addr;
    logic [31:0] wr_data;
    logic        excp_valid;
    logic [5:0]  excp_ecode;
    logic [8:0]  excp_subcode;
    logic [31:0] excp_pc;
    logic        ertn_valid;
    logic [7:0]  hw_int;
    logic [31:0] excp_entry;
    logic [31:0] era_out;
    logic        int_pending;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output excp_valid, excp_ecode, excp_subcode, excp_pc, ertn_valid, hw_int,
        input  rd_data, excp_entry, era_out, int_pending
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  excp_valid, excp_ecode, excp_subcode, excp_pc, ertn_valid, hw_int,
        output rd_data, excp_entry, era_out, int_pending
    );

endinterface

// File: rtl/csr_timer.sv
// Constant timer: TCFG/TVAL storage, down-counter with optional periodic reload and a
// one-cycle TI-set pulse on the TVAL 1->0 transition.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tcfg_we,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_tcfg,
    output logic [31:0] o_tval,
    output logic        o_ti_set
);

    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic        w_en;
    logic        w_periodic;
    logic [31:0] w_reload;

    assign w_en       = r_tcfg[TCFG_EN];
    assign w_periodic = r_tcfg[TCFG_PERIODIC];
    assign w_reload   = {r_tcfg[31:2], 2'b00};

    // A TCFG write in the same cycle restarts the count, so no 1->0 transition happens.
    assign o_ti_set = w_en & (r_tval == 32'd1) & ~i_tcfg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcfg <= '0;
            r_tval <= '0;
        end else if (i_tcfg_we) begin
            r_tcfg <= i_wr_data;
            r_tval <= {i_wr_data[31:2], 2'b00};
        end else if (w_en) begin
            if (r_tval != 32'd0) begin
                r_tval <= r_tval - 32'd1;
            end else if (w_periodic) begin
                r_tval <= w_reload;
            end
        end
    end

    assign o_tcfg = r_tcfg;
    assign o_tval = r_tval;

endmodule

// File: rtl/csr_regfile.sv
// Architectural CSR file: committed writes from WB, exception/ertn state update, interrupt pending.
// Define CSR_TIMER_EN to build the constant timer (TCFG/TVAL/TICLR and ESTAT.TI).
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] TID_RESET    = 32'h0,
    parameter logic [31:0] EENTRY_RESET = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    csr_regfile_if.slave bus
);

    logic [31:0] r_crmd;
    logic [31:0] r_prmd;
    logic [31:0] r_ecfg;
    logic [31:0] r_estat;
    logic [31:0] r_era;
    logic [31:0] r_eentry;
    logic [31:0] r_tid;
    logic [31:0] r_save [4];

    logic        w_wr;
    logic        w_ertn;
    logic        w_we_crmd;
    logic        w_we_prmd;
    logic        w_we_ecfg;
    logic        w_we_estat;
    logic        w_we_era;
    logic        w_we_eentry;
    logic        w_we_save;
    logic        w_we_tid;
    logic        w_ticlr;
    logic        w_ti_set;
    logic [31:0] w_tcfg;
    logic [31:0] w_tval;
    logic [31:0] w_rd_data;

    // The faulting instruction never commits, so an exception drops every same-cycle write.
    assign w_wr   = bus.wr_en & ~bus.excp_valid;
    assign w_ertn = bus.ertn_valid & ~bus.excp_valid;

    assign w_we_crmd   = w_wr && (bus.wr_addr == CSR_CRMD) && !w_ertn;
    assign w_we_prmd   = w_wr && (bus.wr_addr == CSR_PRMD);
    assign w_we_ecfg   = w_wr && (bus.wr_addr == CSR_ECFG);
    assign w_we_estat  = w_wr && (bus.wr_addr == CSR_ESTAT);
    assign w_we_era    = w_wr && (bus.wr_addr == CSR_ERA);
    assign w_we_eentry = w_wr && (bus.wr_addr == CSR_EENTRY);
    assign w_we_save   = w_wr && (bus.wr_addr[13:2] == CSR_SAVE0[13:2]);
    assign w_we_tid    = w_wr && (bus.wr_addr == CSR_TID);
    assign w_ticlr     = w_wr && (bus.wr_addr == CSR_TICLR) && bus.wr_data[0];

`ifdef CSR_TIMER_EN
    logic w_we_tcfg;

    assign w_we_tcfg = w_wr && (bus.wr_addr == CSR_TCFG);

    csr_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tcfg_we (w_we_tcfg),
        .i_wr_data (bus.wr_data),
        .o_tcfg    (w_tcfg),
        .o_tval    (w_tval),
        .o_ti_set  (w_ti_set)
    );
`else
    assign w_tcfg   = '0;
    assign w_tval   = '0;
    assign w_ti_set = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crmd <= RST_CRMD;
        end else if (bus.excp_valid) begin
            r_crmd[2:0] <= 3'b000;
        end else if (w_ertn) begin
            r_crmd[2:0] <= r_prmd[2:0];
        end else if (w_we_crmd) begin
            r_crmd <= csr_merge(r_crmd, bus.wr_data, MASK_CRMD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prmd <= '0;
        end else if (bus.excp_valid) begin
            r_prmd[2:0] <= r_crmd[2:0];
        end else if (w_we_prmd) begin
            r_prmd <= csr_merge(r_prmd, bus.wr_data, MASK_PRMD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_era <= '0;
        end else if (bus.excp_valid) begin
            r_era <= bus.excp_pc;
        end else if (w_we_era) begin
            r_era <= bus.wr_data;
        end
    end

    // ESTAT: software bits [1:0], sampled hw lines [9:2], timer TI [11], Ecode/EsubCode on exception.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estat <= '0;
        end else begin
            r_estat[9:2]     <= bus.hw_int;
            r_estat[ESTAT_TI] <= w_ti_set | (r_estat[ESTAT_TI] & ~w_ticlr);
            if (bus.excp_valid) begin
                r_estat[21:16] <= bus.excp_ecode;
                r_estat[30:22] <= bus.excp_subcode;
            end
            if (w_we_estat) begin
                r_estat[1:0] <= bus.wr_data[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ecfg   <= '0;
            r_eentry <= EENTRY_RESET & MASK_EENTRY;
            r_tid    <= TID_RESET;
        end else begin
            if (w_we_ecfg) begin
                r_ecfg <= csr_merge(r_ecfg, bus.wr_data, MASK_ECFG);
            end
            if (w_we_eentry) begin
                r_eentry <= csr_merge(r_eentry, bus.wr_data, MASK_EENTRY);
            end
            if (w_we_tid) begin
                r_tid <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= '0;
            end
        end else if (w_we_save) begin
            r_save[bus.wr_addr[1:0]] <= bus.wr_data;
        end
    end

    // Reads see committed state only; execute forwards in-flight writes itself.
    always_comb begin
        w_rd_data = '0;
        case (bus.rd_addr)
            CSR_CRMD:   w_rd_data = r_crmd;
            CSR_PRMD:   w_rd_data = r_prmd;
            CSR_ECFG:   w_rd_data = r_ecfg;
            CSR_ESTAT:  w_rd_data = r_estat;
            CSR_ERA:    w_rd_data = r_era;
            CSR_EENTRY: w_rd_data = r_eentry;
            CSR_SAVE0:  w_rd_data = r_save[0];
            CSR_SAVE1:  w_rd_data = r_save[1];
            CSR_SAVE2:  w_rd_data = r_save[2];
            CSR_SAVE3:  w_rd_data = r_save[3];
            CSR_TID:    w_rd_data = r_tid;
            CSR_TCFG:   w_rd_data = w_tcfg;
            CSR_TVAL:   w_rd_data = w_tval;
            default:    w_rd_data = '0;
        endcase
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.excp_entry  = r_eentry;
    assign bus.era_out     = r_era;
    assign bus.int_pending = r_crmd[CRMD_IE] & (|(r_estat[12:0] & r_ecfg[12:0]));

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: directed scenarios plus randomized commit traffic, all checked
// against an address-keyed reference model of the CSR file.
module tb_csr_regfile;
    import csr_pkg::*;

`ifdef CSR_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_regfile_if bus ();

    csr_regfile #(
        .TID_RESET    (32'h1234_5678),
        .EENTRY_RESET (32'h1c00_0fff)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  cur_hw = 8'h00;
    logic [31:0] m_csr [logic [13:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input logic [13:0] a);
        case (a)
            14'h000: return 32'h0000_01ff;
            14'h001: return 32'h0000_0007;
            14'h004: return 32'h0000_1bff;
            14'h005: return 32'h0000_0003;
            14'h00c: return 32'hffff_ffc0;
            14'h042: return 32'h0000_0000;
            default: return 32'hffff_ffff;
        endcase
    endfunction

    task automatic model_reset();
        m_csr.delete();
        m_csr[14'h000] = 32'h8;
        m_csr[14'h001] = 32'h0;
        m_csr[14'h004] = 32'h0;
        m_csr[14'h005] = 32'h0;
        m_csr[14'h006] = 32'h0;
        m_csr[14'h00c] = 32'h1c00_0fc0;
        for (int i = 0; i < 4; i++) m_csr[14'h030 + 14'(i)] = 32'h0;
        m_csr[14'h040] = 32'h1234_5678;
        if (TIMER_ON) begin
            m_csr[14'h041] = 32'h0;
            m_csr[14'h042] = 32'h0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [13:0] a);
        if (m_csr.exists(a)) return m_csr[a];
        return 32'h0;
    endfunction

    function automatic logic model_irq();
        logic [31:0] crmd, estat, ecfg;
        crmd  = m_csr[14'h000];
        estat = m_csr[14'h005];
        ecfg  = m_csr[14'h004];
        return crmd[2] && ((estat[12:0] & ecfg[12:0]) != 13'h0);
    endfunction

    task automatic model_step(input logic we, input logic [13:0] wa, input logic [31:0] wd,
                              input logic ex, input logic [5:0] ec, input logic [8:0] sc,
                              input logic [31:0] pc, input logic er, input logic [7:0] hw);
        logic        commit, ti_fire, ti_clr;
        logic [31:0] crmd0, prmd0, tcfg0, tval0, est;
        crmd0 = m_csr[14'h000];
        prmd0 = m_csr[14'h001];
        tcfg0 = 32'h0;
        tval0 = 32'h0;
        if (TIMER_ON) begin
            tcfg0 = m_csr[14'h041];
            tval0 = m_csr[14'h042];
        end
        commit  = we && !ex;
        ti_fire = 1'b0;
        ti_clr  = commit && TIMER_ON && (wa == 14'h044) && wd[0];
        if (commit && m_csr.exists(wa) && !(wa == 14'h000 && er))
            m_csr[wa] = (m_csr[wa] & ~wmask(wa)) | (wd & wmask(wa));
        est = m_csr[14'h005];
        if (ex) begin
            m_csr[14'h001] = {prmd0[31:3], crmd0[2:0]};
            m_csr[14'h000] = {crmd0[31:3], 3'b000};
            m_csr[14'h006] = pc;
            est[21:16] = ec;
            est[30:22] = sc;
        end else if (er) begin
            m_csr[14'h000] = {crmd0[31:3], prmd0[2:0]};
        end
        if (TIMER_ON) begin
            if (commit && wa == 14'h041) begin
                m_csr[14'h042] = {wd[31:2], 2'b00};
            end else if (tcfg0[0]) begin
                if (tval0 != 32'h0) begin
                    m_csr[14'h042] = tval0 - 32'h1;
                    ti_fire = (tval0 == 32'h1);
                end else if (tcfg0[1]) begin
                    m_csr[14'h042] = {tcfg0[31:2], 2'b00};
                end
            end
        end
        est[9:2] = hw;
        if (ti_fire) est[11] = 1'b1;
        else if (ti_clr) est[11] = 1'b0;
        m_csr[14'h005] = est;
    endtask

    task automatic step(input logic we, input logic [13:0] wa, input logic [31:0] wd,
                        input logic ex, input logic [5:0] ec, input logic [8:0] sc,
                        input logic [31:0] pc, input logic er, input logic [7:0] hw,
                        input logic [13:0] ra);
        bus.wr_en = we;  bus.wr_addr = wa;  bus.wr_data = wd;
        bus.excp_valid = ex;  bus.excp_ecode = ec;  bus.excp_subcode = sc;  bus.excp_pc = pc;
        bus.ertn_valid = er;  bus.hw_int = hw;  bus.rd_addr = ra;
        #1;
        chk("rd_data", bus.rd_data, model_read(ra));
        chk("int_pending", {31'h0, bus.int_pending}, {31'h0, model_irq()});
        chk("excp_entry", bus.excp_entry, model_read(14'h00c));
        chk("era_out", bus.era_out, model_read(14'h006));
        @(posedge clk);
        model_step(we, wa, wd, ex, ec, sc, pc, er, hw);
        #1;
    endtask

    task automatic idle(input logic [13:0] ra = 14'h0);
        step(1'b0, 14'h0, 32'h0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, cur_hw, ra);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, cur_hw, a);
    endtask

    task automatic peek(input string tag, input logic [13:0] a, input logic [31:0] exp);
        bus.rd_addr = a;
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] addrs [16];
        logic [13:0] wa, ra;
        logic [31:0] wd;
        addrs = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h00c, 14'h030, 14'h031,
                  14'h032, 14'h033, 14'h040, 14'h041, 14'h042, 14'h044, 14'h002, 14'h3fff};
        bus.wr_en = 1'b0;  bus.wr_addr = '0;  bus.wr_data = '0;
        bus.excp_valid = 1'b0;  bus.excp_ecode = '0;  bus.excp_subcode = '0;  bus.excp_pc = '0;
        bus.ertn_valid = 1'b0;  bus.hw_int = '0;  bus.rd_addr = '0;
        model_reset();

        #12;
        peek("rst_crmd", 14'h000, 32'h8);
        peek("rst_estat", 14'h005, 32'h0);
        peek("rst_tid", 14'h040, 32'h1234_5678);
        peek("rst_eentry", 14'h00c, 32'h1c00_0fc0);
        chk("rst_int_pending", {31'h0, bus.int_pending}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ERA write: same-cycle read returns the old value (checked inside step)
        wr(14'h006, 32'hdead_beef);
        peek("era_after_wr", 14'h006, 32'hdead_beef);
        chk("era_out_after_wr", bus.era_out, 32'hdead_beef);

        // Exception commit then ertn
        wr(14'h000, 32'h7);
        step(1'b0, 14'h0, 32'h0, 1'b1, ECODE_SYS, 9'h0, 32'h1c00_0100, 1'b0, cur_hw, 14'h000);
        peek("excp_crmd", 14'h000, 32'h0);
        peek("excp_prmd", 14'h001, 32'h7);
        peek("excp_era", 14'h006, 32'h1c00_0100);
        peek("excp_estat", 14'h005, 32'h000b_0000);
        step(1'b0, 14'h0, 32'h0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b1, cur_hw, 14'h000);
        peek("ertn_crmd", 14'h000, 32'h7);

        // Write dropped by same-cycle exception; CRMD write dropped by same-cycle ertn
        step(1'b1, 14'h000, 32'h1ff, 1'b1, ECODE_SYS, 9'h1, 32'h1c00_0200, 1'b0, cur_hw, 14'h000);
        peek("drop_crmd_excp", 14'h000, 32'h0);
        peek("drop_era", 14'h006, 32'h1c00_0200);
        step(1'b1, 14'h000, 32'h1f0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b1, cur_hw, 14'h000);
        peek("drop_crmd_ertn", 14'h000, 32'h7);

        // ESTAT only takes [1:0]; unmapped addresses read 0 and ignore writes
        wr(14'h005, 32'hffff_ffff);
        peek("estat_wmask", 14'h005, 32'h004b_0003);
        wr(14'h007, 32'h5555_aaaa);
        peek("unmapped_007", 14'h007, 32'h0);
        wr(14'h044, 32'h0000_0001);
        peek("ticlr_reads0", 14'h044, 32'h0);
        wr(14'h004, 32'hffff_ffff);
        peek("ecfg_wmask", 14'h004, 32'h0000_1bff);

        // Hardware interrupt line through ECFG[2], one cycle sampling latency
        wr(14'h004, 32'h4);
        wr(14'h000, 32'h4);
        chk("hw_irq_before", {31'h0, bus.int_pending}, 32'h0);
        cur_hw = 8'h01;
        idle();
        chk("hw_irq_after", {31'h0, bus.int_pending}, 32'h1);
        cur_hw = 8'h00;
        idle();
        chk("hw_irq_cleared", {31'h0, bus.int_pending}, 32'h0);

        // Timer
        wr(14'h004, 32'h800);
        wr(14'h041, 32'h0000_000b);
        if (TIMER_ON) begin
            peek("tval_load", 14'h042, 32'h8);
            repeat (7) idle(14'h042);
            peek("tval_one", 14'h042, 32'h1);
            chk("ti_not_yet", {31'h0, bus.int_pending}, 32'h0);
            idle(14'h042);
            peek("tval_zero", 14'h042, 32'h0);
            peek("ti_set", 14'h005, 32'h004b_0803);
            chk("ti_irq", {31'h0, bus.int_pending}, 32'h1);
            idle(14'h042);
            peek("tval_reload", 14'h042, 32'h8);
            wr(14'h044, 32'h1);
            peek("ti_cleared", 14'h005, 32'h004b_0003);
            chk("ti_irq_cleared", {31'h0, bus.int_pending}, 32'h0);
            repeat (6) idle(14'h042);
            peek("tval_one_b", 14'h042, 32'h1);
            wr(14'h044, 32'h1);
            peek("ti_set_wins", 14'h005, 32'h004b_0803);
            wr(14'h044, 32'h1);
            wr(14'h041, 32'h0000_0003);
            repeat (3) idle(14'h042);
            peek("tval_init0", 14'h042, 32'h0);
            peek("ti_init0", 14'h005, 32'h004b_0003);
            wr(14'h041, 32'h0000_0005);
            repeat (4) idle(14'h042);
            peek("oneshot_ti", 14'h005, 32'h004b_0803);
            wr(14'h044, 32'h1);
            repeat (5) idle(14'h042);
            peek("oneshot_hold", 14'h042, 32'h0);
            peek("oneshot_no_ti", 14'h005, 32'h004b_0003);
            wr(14'h041, 32'h0000_000f);
            repeat (3) idle(14'h042);
            peek("tval_midcount", 14'h042, 32'h9);
            @(negedge clk) rst_n = 1'b0;
            #1;
            peek("rst_tval", 14'h042, 32'h0);
            peek("rst_crmd_mid", 14'h000, 32'h8);
            model_reset();
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk);
            #1;
            repeat (2) idle(14'h042);
            peek("tval_stopped", 14'h042, 32'h0);
            peek("tcfg_after_rst", 14'h041, 32'h0);
        end else begin
            peek("tcfg_absent", 14'h041, 32'h0);
            peek("tval_absent", 14'h042, 32'h0);
        end

        // Randomized commit traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wa = addrs[$urandom_range(0, 15)];
            ra = addrs[$urandom_range(0, 15)];
            wd = $urandom();
            if (wa == 14'h041) wd = (32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) cur_hw = 8'($urandom());
            step($urandom_range(0, 1) == 1, wa, wd, $urandom_range(0, 15) == 0,
                 6'($urandom()), 9'($urandom()), $urandom(), $urandom_range(0, 11) == 0,
                 cur_hw, ra);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
